// File: rtl/disparity_pkg.sv
// Shared word geometry, DBIT derivation and FIFO payload type for disparity_packer.
`default_nettype none

package disparity_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = 32;

  function automatic int calc_dbit(input int d);
    return (d <= 1) ? 1 : $clog2(d);
  endfunction

  typedef struct packed {
    logic [WORD_W-1:0] tdata;
    logic              tlast;
    logic              tuser;
  } word_t;

endpackage

`default_nettype wire

// File: rtl/disparity_packer_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is only taken if a pop frees a slot that cycle.
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = empty ? '0 : mem[rd_ptr];
    level   = count;
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/disparity_packer.sv
// Packs per-pixel disparities into 4-lane 32-bit words with line/frame markers,
// buffered in a FIFO; words arriving at a full FIFO are dropped and flagged.
`default_nettype none

module disparity_packer
  import disparity_pkg::*;
#(
  parameter int D          = 64,
  parameter int M          = 450,
  parameter int ROWS       = 375,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_dval,
  input  logic [calc_dbit(D)-1:0]      i_data,
  output logic                         o_tvalid,
  input  logic                         i_tready,
  output logic [WORD_W-1:0]            o_tdata,
  output logic                         o_tlast,
  output logic                         o_tuser,
  output logic                         o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]  o_level
);

  localparam int DBIT  = calc_dbit(D);
  localparam int COL_W = ($clog2(M + 1) < 2) ? 2 : $clog2(M + 1);
  localparam int ROW_W = ($clog2(ROWS + 1) < 1) ? 1 : $clog2(ROWS + 1);

  generate
    if (DBIT > LANE_W) begin : g_dbit_check
      $error("disparity_packer: DBIT must not exceed 8");
    end
  endgenerate

  logic [COL_W-1:0]                col;
  logic [ROW_W-1:0]                row;
  logic [LANES-1:0][LANE_W-1:0]    lanes_q;
  logic [LANES-1:0][LANE_W-1:0]    word_lanes;
  logic [1:0]                      lane;
  logic                            last_col;
  logic                            complete;
  logic                            pop;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic                            overflow;
  word_t                           wr_word;
  word_t                           rd_word;

  always_comb begin
    lane             = col[1:0];
    last_col         = (col == COL_W'(M - 1));
    complete         = i_dval && (lane == 2'd3 || last_col);
    word_lanes       = lanes_q;
    word_lanes[lane] = LANE_W'(i_data);
    wr_word.tdata    = word_lanes;
    wr_word.tlast    = last_col;
    wr_word.tuser    = (row == '0) && (col < COL_W'(LANES));
    pop              = o_tvalid && i_tready;
  end

  // Position and partial-word state advance only on valid beats; the lane
  // register is cleared on completion so unused trailing lanes read as zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col      <= '0;
      row      <= '0;
      lanes_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (i_dval) begin
        if (last_col) begin
          col <= '0;
          row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        if (complete) lanes_q       <= '0;
        else          lanes_q[lane] <= LANE_W'(i_data);
      end
      if (complete && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .push   (complete),
    .wdata  (wr_word),
    .pop    (pop),
    .rdata  (rd_word),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (o_level)
  );

  always_comb begin
    o_tvalid   = !fifo_empty;
    o_tdata    = rd_word.tdata;
    o_tlast    = rd_word.tlast;
    o_tuser    = rd_word.tuser;
    o_overflow = overflow;
  end

endmodule

`default_nettype wire

// File: tb/tb_disparity_packer.sv
// Directed bench for disparity_packer with M=6, ROWS=2, FIFO_DEPTH=4.
`default_nettype none

module tb_disparity_packer;

  logic        clk;
  logic        rstn;
  logic        dval;
  logic [5:0]  data;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic        tuser;
  logic        overflow;
  logic [2:0]  level;

  int checks   = 0;
  int failures = 0;

  logic [33:0] got[$];
  logic [33:0] exp_q[$];

  disparity_packer #(
    .D          (64),
    .M          (6),
    .ROWS       (2),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_dval     (dval),
    .i_data     (data),
    .o_tvalid   (tvalid),
    .i_tready   (tready),
    .o_tdata    (tdata),
    .o_tlast    (tlast),
    .o_tuser    (tuser),
    .o_overflow (overflow),
    .o_level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words are captured mid-cycle; the pop itself happens on the following edge.
  always @(negedge clk) begin
    if (rstn && tvalid && tready) got.push_back({tdata, tlast, tuser});
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [33:0] w(input logic [31:0] d, input logic l, input logic u);
    return {d, l, u};
  endfunction

  task automatic beat(input int v);
    dval = 1'b1;
    data = 6'(v);
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    dval = 1'b0;
    data = 6'($urandom_range(63, 0));
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    dval = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    tready = 1'b1;
    while (tvalid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_idle", tvalid, 1'b0);
  endtask

  task automatic compare_words(input string tag);
    check($sformatf("%s_count", tag), got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    rstn   = 1'b0;
    dval   = 1'b0;
    data   = '0;
    tready = 1'b0;
    do_reset();

    check("rst_tvalid",   tvalid,   1'b0);
    check("rst_tdata",    tdata,    32'h0);
    check("rst_tlast",    tlast,    1'b0);
    check("rst_tuser",    tuser,    1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_level",    level,    3'd0);

    // Three lines back to back: frame wraps after two rows.
    tready = 1'b1;
    got.delete();
    beat(1); beat(2); beat(3);
    check("tvalid_before_word", tvalid, 1'b0);
    beat(4);
    check("tvalid_after_word", tvalid, 1'b1);
    beat(5); beat(6);
    for (int v = 7; v <= 18; v++) beat(v);
    gap(1);
    drain();
    exp_q.push_back(w(32'h04030201, 1'b0, 1'b1));
    exp_q.push_back(w(32'h00000605, 1'b1, 1'b0));
    exp_q.push_back(w(32'h0A090807, 1'b0, 1'b0));
    exp_q.push_back(w(32'h00000C0B, 1'b1, 1'b0));
    exp_q.push_back(w(32'h100F0E0D, 1'b0, 1'b1));
    exp_q.push_back(w(32'h00001211, 1'b1, 1'b0));
    compare_words("stream");

    // Position is now row 1, col 0; gaps must not disturb packing.
    beat(5); gap(2); beat(6); gap(1); beat(7); beat(8);
    beat(9); beat(10);
    gap(1);
    drain();
    exp_q.push_back(w(32'h08070605, 1'b0, 1'b0));
    exp_q.push_back(w(32'h00000A09, 1'b1, 1'b0));
    compare_words("gaps");

    // Overflow: six words into a depth-4 FIFO with no consumer.
    do_reset();
    tready = 1'b0;
    for (int v = 1; v <= 18; v++) beat(v);
    gap(1);
    check("ovf_level",    level,    3'd4);
    check("ovf_flag",     overflow, 1'b1);
    check("ovf_head",     tdata,    32'h04030201);
    gap(3);
    check("ovf_head_hold", tdata,   32'h04030201);
    drain();
    exp_q.push_back(w(32'h04030201, 1'b0, 1'b1));
    exp_q.push_back(w(32'h00000605, 1'b1, 1'b0));
    exp_q.push_back(w(32'h0A090807, 1'b0, 1'b0));
    exp_q.push_back(w(32'h00000C0B, 1'b1, 1'b0));
    compare_words("ovf_drain");
    check("ovf_sticky", overflow, 1'b1);
    do_reset();
    check("ovf_cleared", overflow, 1'b0);

    // Full FIFO with a pop on the same edge as a push: accepted, no overflow.
    tready = 1'b0;
    for (int v = 1; v <= 12; v++) beat(v);
    gap(1);
    check("full_level", level, 3'd4);
    beat(13); beat(14); beat(15);
    tready = 1'b1;
    beat(16);
    tready = 1'b0;
    dval   = 1'b0;
    check("pushpop_level",    level,    3'd4);
    check("pushpop_overflow", overflow, 1'b0);
    drain();
    exp_q.push_back(w(32'h04030201, 1'b0, 1'b1));
    exp_q.push_back(w(32'h00000605, 1'b1, 1'b0));
    exp_q.push_back(w(32'h0A090807, 1'b0, 1'b0));
    exp_q.push_back(w(32'h00000C0B, 1'b1, 1'b0));
    exp_q.push_back(w(32'h100F0E0D, 1'b0, 1'b1));
    compare_words("pushpop");

    // Reset mid-line discards the partial word and restarts at frame origin.
    do_reset();
    tready = 1'b1;
    beat(1); beat(2);
    do_reset();
    for (int v = 9; v <= 14; v++) beat(v);
    gap(1);
    drain();
    exp_q.push_back(w(32'h0C0B0A09, 1'b0, 1'b1));
    exp_q.push_back(w(32'h00000E0D, 1'b1, 1'b0));
    compare_words("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/disparity_packer.md
Name: disparity_packer

Overview:
- Downstream consumer of the stereo core's disparity stream (o_dval / o_data).
- Collects one DBIT-bit disparity per valid beat.
- Tracks column and row position within the frame and packs 4 disparities per 32-bit word, one byte lane each.
- Emits words on a valid/ready stream with line-end and frame-start markers, buffered in a small FIFO.
- The disparity source has no backpressure, so FIFO overflow drops words and raises a sticky flag.

Parameters:
- D, 64, disparity range; DBIT = $clog2(D). DBIT must be <= 8; elaborate-time error otherwise.
- M, 450, pixels per line.
- ROWS, 375, lines per frame.
- FIFO_DEPTH, 8, word FIFO depth; power of 2, >= 2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_dval  in  1  disparity valid (from stereo core o_dval).
- i_data  in  DBIT  disparity value (from stereo core o_data).
- o_tvalid  out  1  output word valid.
- i_tready  in  1  downstream ready.
- o_tdata  out  32  packed word; lane k = bits 8k+7:8k, zero-extended disparity.
- o_tlast  out  1  word carries the last pixel of a line.
- o_tuser  out  1  first word of a frame (row 0, col 0..3).
- o_overflow  out  1  sticky; a word was dropped because the FIFO was full.
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: all outputs 0. Counters, lane register, FIFO pointers and overflow flag are cleared. A reset mid-line discards the partial word, and the next i_dval is treated as row 0, col 0.
- Position counters:
  - col counts 0..M-1 and row counts 0..ROWS-1. Both advance only on i_dval=1.
  - At col=M-1, col wraps to 0 and row increments. At row=ROWS-1 with col=M-1, both wrap to 0.
  - i_dval gaps of any length are allowed and position is held across them.
- Packing:
  - lane = col mod 4. The pixel at col c goes to lane c mod 4 of word floor(c/4).
  - A beat completes a word when lane=3 or col=M-1.
  - Completed word = held lanes + current i_data in its lane. Lanes beyond the final pixel of a line are 0.
  - The lane register is cleared after each completed word.
  - Words never span lines. Each line yields ceil(M/4) words; M=450 gives 113 words, and the last word carries 2 pixels.
- Sideband per word: tlast = (col==M-1 at completion); tuser = (row==0 && word index 0).
- FIFO push:
  - A completed word is written on the same rising edge that samples the completing beat.
  - FIFO is show-ahead. With an empty FIFO, o_tvalid rises 1 cycle after that edge.
- Output handshake:
  - A pop occurs when o_tvalid && i_tready.
  - o_tdata, o_tlast and o_tuser stay stable while o_tvalid=1 and i_tready=0.
  - o_tvalid never drops without a pop.
- Full FIFO:
  - A push while full with no pop in the same cycle drops the word and sets o_overflow, which stays set until reset. Counters still advance.
  - Simultaneous push and pop while full is accepted: level unchanged, no overflow.
- Empty FIFO: a pop cannot occur, since o_tvalid=0.
- o_level: +1 on push only, -1 on pop only, unchanged on both.

Decomposition:
- Package disparity_pkg: DBIT derivation function, LANES=4, LANE_W=8, WORD_W=32, and the struct {tdata, tlast, tuser} used as FIFO payload.
- One sub-module, sync_fifo: parameterized width/depth, show-ahead, push/pop/full/empty/level, async active-low reset on i_clk/i_rstn.
- Packer, counters and overflow logic live in the top.

Test Plan (M=6, ROWS=2, FIFO_DEPTH=4 unless stated):
- Reset, then a continuous stream of disparities 1..6 with i_tready=1 -> words 0x04030201 (tuser=1, tlast=0) then 0x00000605 (tuser=0, tlast=1). First o_tvalid appears 1 cycle after the edge sampling pixel 4.
- Second line 7..12, then third line 13..18 -> 0x0A090807, 0x00000C0B (tlast=1), then 0x100F0E0D with tuser=1, showing the row wrap back to frame start.
- i_dval pattern 1,0,0,1,0,1,1 with data 5,x,x,6,x,7,8 -> single word 0x08070605. Gaps do not disturb packing.
- i_tready=0 for 3 lines (6 words pushed, depth 4) -> o_level saturates at 4 and o_overflow=1. After i_tready=1, exactly the first 4 words drain in order. o_overflow stays 1 until i_rstn pulse.
- FIFO full, i_tready=1 on the same cycle a word completes -> push accepted, o_level stays 4, o_overflow stays 0.
- i_rstn asserted after pixels 1,2 of a line, then pixels 9..14 -> first output word 0x0C0B0A09 with tuser=1. The partial word from before reset is never emitted.
